vlc_ac_scheduler: RTL and testbench

Sequences one slice of quantized AC coefficients, in scan order, into the exp-Golomb codeword-length datapath. It converts the coefficient stream into alternating run and level requests and selects the Golomb parameter k for each request from adaptive codebooks. It also drives the datapath's start/valid/end framing. It sits between the scan/quantizer output and the exp-Golomb stage in the VLC path.

---
 rtl/vlc_ac_scheduler.sv | 138 +++++++++++++
 tb/tb_vlc_ac_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vlc_ac_scheduler.sv
// AC coefficient scheduler: turns a scan-order coefficient stream into alternating
// run/level requests with adaptive Golomb k for the exp-Golomb length datapath.
module vlc_ac_scheduler (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_start,
  input  logic               in_end,
  input  logic signed [15:0] in_coef,
  output logic               out_valid,
  output logic               out_start,
  output logic               out_end,
  output logic [31:0]        out_val,
  output logic [2:0]         out_k,
  output logic [1:0]         out_is_add_setbit,
  output logic               out_is_ac_level,
  output logic               out_is_ac_minus_n,
  output logic               slice_done
);

  typedef enum logic {ACCEPT = 1'b0, LEVEL = 1'b1} state_t;

  state_t      state, state_next;
  logic [15:0] run_cnt, prev_run;
  logic [16:0] prev_lvl, abs_q;
  logic        sign_q, end_q, first_pend;

  logic        accept, coef_zero;
  logic [15:0] run_eff, prev_run_eff;
  logic [16:0] prev_lvl_eff, coef_ext, coef_abs;
  logic        first_eff;

  function automatic logic [2:0] kr(input logic [15:0] p);
    if (p < 16'd2)      return 3'd0;
    else if (p < 16'd4) return 3'd1;
    else if (p < 16'd8) return 3'd2;
    else                return 3'd3;
  endfunction

  function automatic logic [2:0] kl(input logic [16:0] p);
    if (p <= 17'd1)      return 3'd0;
    else if (p == 17'd2) return 3'd1;
    else if (p <= 17'd4) return 3'd2;
    else                 return 3'd3;
  endfunction

  assign in_ready          = (state == ACCEPT);
  assign accept            = in_valid && in_ready;
  assign coef_zero         = (in_coef == 16'sd0);
  assign out_is_add_setbit = 2'b00;
  // 17-bit magnitude so that -32768 maps to 32768 without overflow
  assign coef_ext          = {in_coef[15], in_coef};
  assign coef_abs          = in_coef[15] ? (17'd0 - coef_ext) : coef_ext;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next   = state;
    run_eff      = run_cnt;
    prev_run_eff = prev_run;
    prev_lvl_eff = prev_lvl;
    first_eff    = first_pend;
    if (accept && in_start) begin
      run_eff      = 16'd0;
      prev_run_eff = 16'd4;
      prev_lvl_eff = 17'd1;
      first_eff    = 1'b1;
    end
    case (state)
      ACCEPT:  if (accept && !coef_zero) state_next = LEVEL;
      LEVEL:   state_next = ACCEPT;
      default: state_next = ACCEPT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ACCEPT;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt           <= 16'd0;
      prev_run          <= 16'd4;
      prev_lvl          <= 17'd1;
      first_pend        <= 1'b0;
      abs_q             <= 17'd0;
      sign_q            <= 1'b0;
      end_q             <= 1'b0;
      out_valid         <= 1'b0;
      out_start         <= 1'b0;
      out_end           <= 1'b0;
      out_val           <= 32'd0;
      out_k             <= 3'd0;
      out_is_ac_level   <= 1'b0;
      out_is_ac_minus_n <= 1'b0;
      slice_done        <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_start  <= 1'b0;
      out_end    <= 1'b0;
      slice_done <= 1'b0;
      if (state == LEVEL) begin
        out_valid         <= 1'b1;
        out_val           <= {15'd0, abs_q - 17'd1};
        out_k             <= kl(prev_lvl);
        out_is_ac_level   <= 1'b1;
        out_is_ac_minus_n <= sign_q;
        out_end           <= end_q;
        slice_done        <= end_q;
        prev_lvl          <= abs_q;
      end else if (accept) begin
        prev_lvl   <= prev_lvl_eff;
        first_pend <= first_eff;
        if (coef_zero) begin
          run_cnt    <= (run_eff == 16'hFFFF) ? run_eff : run_eff + 16'd1;
          prev_run   <= prev_run_eff;
          slice_done <= in_end;
        end else begin
          out_valid         <= 1'b1;
          out_val           <= {16'd0, run_eff};
          out_k             <= kr(prev_run_eff);
          out_is_ac_level   <= 1'b0;
          out_is_ac_minus_n <= 1'b0;
          out_start         <= first_eff;
          first_pend        <= 1'b0;
          abs_q             <= coef_abs;
          sign_q            <= in_coef[15];
          end_q             <= in_end;
          prev_run          <= run_eff;
          run_cnt           <= 16'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vlc_ac_scheduler.sv
// Randomized and directed bench for vlc_ac_scheduler, compared cycle by cycle
// against a request-list model of the slice coding rules.
module tb_vlc_ac_scheduler;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid, in_start, in_end;
  logic signed [15:0] in_coef;
  logic               in_ready;
  logic               out_valid, out_start, out_end, slice_done;
  logic [31:0]        out_val;
  logic [2:0]         out_k;
  logic [1:0]         out_is_add_setbit;
  logic               out_is_ac_level, out_is_ac_minus_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vlc_ac_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_end(in_end),
    .in_coef(in_coef),
    .out_valid(out_valid), .out_start(out_start), .out_end(out_end),
    .out_val(out_val), .out_k(out_k), .out_is_add_setbit(out_is_add_setbit),
    .out_is_ac_level(out_is_ac_level), .out_is_ac_minus_n(out_is_ac_minus_n),
    .slice_done(slice_done)
  );

  typedef struct {
    bit        v, st, en, done, lvl, mn;
    bit [31:0] val;
    bit [2:0]  k;
  } req_t;

  // Model state: what the coding rules say, independent of the RTL structure
  req_t      pend;
  int        m_run, m_prev_run, m_prev_lvl;
  bit        m_first, m_ready;
  bit [31:0] h_val;
  bit [2:0]  h_k;
  bit        h_lvl, h_mn;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int kr(input int p);
    if (p < 2) return 0;
    if (p < 4) return 1;
    if (p < 8) return 2;
    return 3;
  endfunction

  function automatic int kl(input int p);
    if (p <= 1) return 0;
    if (p == 2) return 1;
    if (p <= 4) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    pend       = '{default: 0};
    m_run      = 0;
    m_prev_run = 4;
    m_prev_lvl = 1;
    m_first    = 0;
    m_ready    = 1;
    h_val      = 0;
    h_k        = 0;
    h_lvl      = 0;
    h_mn       = 0;
  endtask

  // One clock: drive at negedge, predict, step to next negedge, compare.
  task automatic cycle(input bit v, input bit st, input bit en, input logic signed [15:0] c,
                       output bit acc);
    req_t exp_now;
    int   a;
    in_valid = v;
    in_start = st;
    in_end   = en;
    in_coef  = c;
    #1;
    check("in_ready", 48'(in_ready), 48'(m_ready));
    acc     = v && m_ready;
    exp_now = pend;
    pend    = '{default: 0};
    if (acc) begin
      if (st) begin
        m_run      = 0;
        m_prev_run = 4;
        m_prev_lvl = 1;
        m_first    = 1;
      end
      if (c == 0) begin
        m_run        = (m_run < 65535) ? m_run + 1 : 65535;
        exp_now.done = en;
      end else begin
        a = (c < 0) ? -int'(c) : int'(c);
        exp_now = '{v: 1, st: m_first, en: 0, done: 0, lvl: 0, mn: 0,
                    val: 32'(m_run), k: 3'(kr(m_prev_run))};
        pend    = '{v: 1, st: 0, en: en, done: en, lvl: 1, mn: (c < 0),
                    val: 32'(a - 1), k: 3'(kl(m_prev_lvl))};
        m_prev_run = m_run;
        m_run      = 0;
        m_first    = 0;
        m_prev_lvl = a;
      end
    end
    m_ready = !(acc && c != 0);
    @(posedge clk);
    @(negedge clk);
    if (exp_now.v) begin
      h_val = exp_now.val;
      h_k   = exp_now.k;
      h_lvl = exp_now.lvl;
      h_mn  = exp_now.mn;
    end
    check("pulses", 48'({out_valid, out_start, out_end, slice_done}),
          48'({exp_now.v, exp_now.st, exp_now.en, exp_now.done}));
    check("data", 48'({out_val, out_k, out_is_ac_level, out_is_ac_minus_n, out_is_add_setbit}),
          48'({h_val, h_k, h_lvl, h_mn, 2'b00}));
  endtask

  task automatic send_beat(input bit st, input bit en, input logic signed [15:0] c);
    bit acc;
    int tries = 0;
    do begin
      cycle(1'b1, st, en, c, acc);
      tries++;
    end while (!acc && tries < 4);
    if (!acc) check("accept_timeout", 48'd0, 48'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'sd0, acc);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_start = 1'b0;
    in_end   = 1'b0;
    in_coef  = 16'sd0;
    reset_n  = 1'b0;
    #1;
    check("reset_outs", 48'({out_valid, out_start, out_end, slice_done, out_val, out_k,
                             out_is_ac_level, out_is_ac_minus_n, out_is_add_setbit}), 48'd0);
    check("reset_ready", 48'(in_ready), 48'd1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic signed [15:0] rand_coef();
    logic signed [15:0] c;
    int r = $urandom_range(0, 9);
    if (r < 5) c = 16'sd0;
    else if (r < 8) begin
      c = 16'($urandom_range(1, 9));
      if ($urandom_range(0, 1) == 1) c = -c;
    end else if (r == 8) c = 16'($urandom);
    else begin
      case ($urandom_range(0, 3))
        0:       c = 16'sh8000;
        1:       c = 16'sh7FFF;
        2:       c = -16'sd1;
        default: c = 16'sd1;
      endcase
    end
    return c;
  endfunction

  initial begin
    bit acc;
    int len;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_end   = 1'b0;
    in_coef  = 16'sd0;
    reset_n  = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();
    idle(2);

    // Basic slice
    send_beat(1, 0, 16'sd0);
    send_beat(0, 0, 16'sd0);
    send_beat(0, 1, 16'sd5);
    idle(3);

    // Back-to-back nonzero
    send_beat(1, 0, -16'sd1);
    send_beat(0, 0, 16'sd3);
    send_beat(0, 1, 16'sd7);
    idle(3);

    // All-zero slice of 63 beats
    for (int i = 0; i < 63; i++) send_beat(i == 0, i == 62, 16'sd0);
    idle(3);

    // Trailing zeros
    send_beat(1, 0, 16'sd2);
    send_beat(0, 0, 16'sd0);
    send_beat(0, 1, 16'sd0);
    idle(3);

    // Single-coefficient slice with start and end together, most negative value
    send_beat(1, 1, 16'sh8000);
    idle(3);

    // Run counter saturation
    send_beat(1, 0, 16'sd0);
    for (int i = 0; i < 65539; i++) send_beat(0, 0, 16'sd0);
    send_beat(0, 1, -16'sd9);
    idle(3);

    // Reset while a level request is pending
    send_beat(1, 0, 16'sd5);
    apply_reset();
    idle(4);
    send_beat(0, 1, 16'sd4);
    idle(3);

    // Randomized slices with random gaps
    for (int s = 0; s < 150; s++) begin
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        send_beat((i == 0) && ($urandom_range(0, 9) != 0), i == len - 1, rand_coef());
        if ($urandom_range(0, 3) == 0)
          cycle(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), acc);
      end
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
